// File: rtl/exec_unit_if.sv
// Command/result bundle between the issue logic, the execute stage and the register-file write port.
interface exec_unit_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = 2
);
  logic              start;
  logic [2:0]        op;
  logic [SEL_W-1:0]  dest_sel;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic              busy;
  logic              done;
  logic              write_bit;
  logic [SEL_W-1:0]  selector_e;
  logic [DATA_W-1:0] data_out;
  logic              flag_z;
  logic              flag_c;

  modport master (
    output start, op, dest_sel, operand_a, operand_b,
    input  busy, done, write_bit, selector_e, data_out, flag_z, flag_c
  );

  modport slave (
    input  start, op, dest_sel, operand_a, operand_b,
    output busy, done, write_bit, selector_e, data_out, flag_z, flag_c
  );
endinterface

// File: rtl/exec_unit.sv
// Multi-cycle execute stage: single-cycle ALU/shift ops plus an optional shift-add multiplier.
// EXEC_MUL_EN enables the DATA_W-cycle multiplier on op 111; otherwise op 111 completes with no write.
module exec_unit #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = 2
) (
  input logic        CLK,
  input logic        areset,
  exec_unit_if.slave bus
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

`ifdef EXEC_MUL_EN
  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned PROD_W = 2 * DATA_W;
  typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE} state_t;
`endif

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              write_q, write_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              z_q, z_d;
  logic              c_q, c_d;

  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic [DATA_W:0]   sum_ext;
  logic [DATA_W:0]   diff_ext;

`ifdef EXEC_MUL_EN
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  dest_q, dest_d;
  logic [PROD_W-1:0] acc_next;
`endif

  // Single-cycle datapath, evaluated straight from the live operands at the accepting edge.
  always_comb begin
    alu_res  = '0;
    alu_c    = 1'b0;
    sum_ext  = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
    diff_ext = {1'b0, bus.operand_a} - {1'b0, bus.operand_b};
    case (bus.op)
      OP_ADD: begin alu_res = sum_ext[DATA_W-1:0];  alu_c = sum_ext[DATA_W];  end
      OP_SUB: begin alu_res = diff_ext[DATA_W-1:0]; alu_c = diff_ext[DATA_W]; end
      OP_AND: alu_res = bus.operand_a & bus.operand_b;
      OP_OR:  alu_res = bus.operand_a | bus.operand_b;
      OP_XOR: alu_res = bus.operand_a ^ bus.operand_b;
      OP_SHL: begin
        alu_res = {bus.operand_a[DATA_W-2:0], 1'b0};
        alu_c   = bus.operand_a[DATA_W-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, bus.operand_a[DATA_W-1:1]};
        alu_c   = bus.operand_a[0];
      end
      default: begin alu_res = '0; alu_c = 1'b0; end
    endcase
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    write_d = 1'b0;
    sel_d   = '0;
    data_d  = '0;
    z_d     = z_q;
    c_d     = c_q;
`ifdef EXEC_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    dest_d   = dest_q;
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          busy_d = 1'b1;
          if (bus.op == OP_MUL) begin
`ifdef EXEC_MUL_EN
            state_d  = CALC;
            acc_d    = '0;
            mcand_d  = {{DATA_W{1'b0}}, bus.operand_a};
            mplier_d = bus.operand_b;
            cnt_d    = '0;
            dest_d   = bus.dest_sel;
`else
            // Unsupported multiply still completes so the issuer is not left waiting.
            state_d = WRITE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = WRITE;
            done_d  = 1'b1;
            write_d = 1'b1;
            sel_d   = bus.dest_sel;
            data_d  = alu_res;
            z_d     = (alu_res == '0);
            c_d     = alu_c;
          end
        end
      end
`ifdef EXEC_MUL_EN
      CALC: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = CNT_W'(cnt_q + 1'b1);
        // Last multiplier bit folds straight into the write-cycle registers.
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = WRITE;
          done_d  = 1'b1;
          write_d = 1'b1;
          sel_d   = dest_q;
          data_d  = acc_next[DATA_W-1:0];
          z_d     = (acc_next[DATA_W-1:0] == '0);
          c_d     = |acc_next[PROD_W-1:DATA_W];
        end
      end
`endif
      WRITE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge areset) begin
    if (!areset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      write_q  <= 1'b0;
      sel_q    <= '0;
      data_q   <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
`ifdef EXEC_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      dest_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      write_q  <= write_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      z_q      <= z_d;
      c_q      <= c_d;
`ifdef EXEC_MUL_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      dest_q   <= dest_d;
`endif
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.write_bit  = write_q;
  assign bus.selector_e = sel_q;
  assign bus.data_out   = data_q;
  assign bus.flag_z     = z_q;
  assign bus.flag_c     = c_q;

endmodule
